// File: rtl/pipe_pkg.sv
// pipe_pkg: types and constants shared by every inter-stage pipeline register
// of the core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   NOP_INSTR    - bubble instruction, addi x0,x0,0
//   PC_W_DEF     - default address field width
//   INSTR_W_DEF  - default instruction/payload field width
//   pipe_beat_t  - {pc, instr} beat at the default widths
package pipe_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } pipe_beat_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: single holding register (valid + {pc, instr}) used as the
// main entry of pipe_stage_reg and, when the skid option is built, as the
// skid entry in front of it.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   flush              - drop the held beat (valid=0, instr=NOP_VAL)
//   load               - capture ld_pc/ld_instr and mark valid
//   clear              - beat handed on: valid=0, instr=NOP_VAL, pc holds
//   ld_pc, ld_instr    - payload to capture on load
//   vld, pc, instr     - held entry
// Precedence: reset > flush > load > clear.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int                 PC_W    = PC_W_DEF,
  parameter int                 INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_VAL = INSTR_W'(NOP_INSTR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               load,
  input  logic               clear,
  input  logic [PC_W-1:0]    ld_pc,
  input  logic [INSTR_W-1:0] ld_instr,
  output logic               vld,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld   <= 1'b0;
      pc    <= '0;
      instr <= NOP_VAL;
    end else if (flush) begin
      vld   <= 1'b0;
      instr <= NOP_VAL;
    end else if (load) begin
      vld   <= 1'b1;
      pc    <= ld_pc;
      instr <= ld_instr;
    end else if (clear) begin
      vld   <= 1'b0;
      instr <= NOP_VAL;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register carrying a {pc, instr} beat
// with valid/ready handshake, flush-to-bubble and backpressure.
// Optional build macro: PIPE_STAGE_SKID_EN adds a skid entry so that in_ready
// is a flop output; without it in_ready is combinational from out_ready.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   flush                          - drop held beats and the current input beat
//   in_valid, in_ready             - upstream handshake
//   in_pc, in_instr                - upstream payload
//   out_valid, out_ready           - downstream handshake
//   out_pc, out_instr              - held payload (out_instr=NOP_VAL when idle)
//   occupancy                      - held entries (0..1, or 0..2 with skid)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 PC_W    = PC_W_DEF,
  parameter int                 INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_VAL = INSTR_W'(NOP_INSTR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  logic               accept;
  logic               deliver;
  logic               main_load;
  logic               main_clear;
  logic [PC_W-1:0]    main_ld_pc;
  logic [INSTR_W-1:0] main_ld_instr;

  logic               vld_p1;
  logic [PC_W-1:0]    pc_p1;
  logic [INSTR_W-1:0] instr_p1;

  assign accept  = in_valid & in_ready;
  assign deliver = vld_p1 & out_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic               main_free;
  logic               skid_load;
  logic               skid_clear;
  logic               vld_p0;
  logic [PC_W-1:0]    pc_p0;
  logic [INSTR_W-1:0] instr_p0;

  // in_ready is the inverse of the skid valid flop, so upstream sees a stall
  // one cycle after the skid fills and no combinational path from out_ready.
  assign in_ready  = ~vld_p0;
  assign main_free = ~vld_p1 | out_ready;

  // Main refills from the skid first to keep order; the skid is only ever
  // full while the main entry is full, so the skid alone never holds a beat.
  assign main_load     = main_free & (vld_p0 | accept);
  assign main_ld_pc    = vld_p0 ? pc_p0    : in_pc;
  assign main_ld_instr = vld_p0 ? instr_p0 : in_instr;
  assign main_clear    = deliver & ~vld_p0 & ~accept;

  assign skid_load  = accept & ~main_free;
  assign skid_clear = vld_p0 & main_free;

  // ---- stage p0: skid entry ----
  pipe_skid_entry #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .NOP_VAL (NOP_VAL)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .load     (skid_load),
    .clear    (skid_clear),
    .ld_pc    (in_pc),
    .ld_instr (in_instr),
    .vld      (vld_p0),
    .pc       (pc_p0),
    .instr    (instr_p0)
  );

  assign occupancy = {1'b0, vld_p1} + {1'b0, vld_p0};

`else

  // Single entry: free when empty or when its beat leaves this cycle, which
  // lets accept and deliver coincide for one beat per cycle.
  assign in_ready      = ~vld_p1 | out_ready;
  assign main_load     = accept;
  assign main_ld_pc    = in_pc;
  assign main_ld_instr = in_instr;
  assign main_clear    = deliver & ~accept;

  assign occupancy = {1'b0, vld_p1};

`endif

  // ---- stage p1: main (output) entry ----
  pipe_skid_entry #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .NOP_VAL (NOP_VAL)
  ) u_main (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .load     (main_load),
    .clear    (main_clear),
    .ld_pc    (main_ld_pc),
    .ld_instr (main_ld_instr),
    .vld      (vld_p1),
    .pc       (pc_p1),
    .instr    (instr_p1)
  );

  assign out_valid = vld_p1;
  assign out_pc    = pc_p1;
  assign out_instr = instr_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg at default widths.
// Expectations adapt to PIPE_STAGE_SKID_EN where the two builds differ.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .occupancy (occupancy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    step(); step();
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=00000000", out_pc); end
    total++; if (out_instr !== NOP) begin bad++; $display("FAIL rst_instr got=%h exp=%h", out_instr, NOP); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_streaming();
    pipe_beat_t vec [3];
    vec[0] = '{pc: 32'h0, instr: 32'h0050_0093};
    vec[1] = '{pc: 32'h4, instr: 32'h00A0_0113};
    vec[2] = '{pc: 32'h8, instr: 32'h0020_81B3};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = vec[i].pc; in_instr = vec[i].instr;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
      total++; if (out_pc !== vec[i].pc) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, vec[i].pc); end
      total++; if (out_instr !== vec[i].instr) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, out_instr, vec[i].instr); end
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%b exp=0", out_valid); end
    total++; if (out_instr !== NOP) begin bad++; $display("FAIL stream_drain_instr got=%h exp=%h", out_instr, NOP); end
    total++; if (out_pc !== 32'h8) begin bad++; $display("FAIL stream_drain_pc got=%h exp=00000008", out_pc); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h10; in_instr = 32'h1111_0013;
    step();
    total++; if (out_pc !== 32'h10) begin bad++; $display("FAIL bp_load_pc got=%h exp=00000010", out_pc); end
    in_pc = 32'h14; in_instr = 32'h2222_0013;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_skid_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_skid_occ got=%0d exp=2", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_skid_in_ready_drop got=%b exp=0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (out_pc !== 32'h10 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] pc=%h valid=%b exp pc=00000010 valid=1", i, out_pc, out_valid); end
      total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_hold_occ[%0d] got=%0d exp=2", i, occupancy); end
    end
    out_ready = 1'b1;
    step();
    total++; if (out_pc !== 32'h14 || out_instr !== 32'h2222_0013) begin bad++; $display("FAIL bp_second pc=%h instr=%h exp pc=00000014 instr=22220013", out_pc, out_instr); end
    total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release occ=%0d in_ready=%b exp occ=1 in_ready=1", occupancy, in_ready); end
`else
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_pc !== 32'h10 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] pc=%h valid=%b exp pc=00000010 valid=1", i, out_pc, out_valid); end
      total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL bp_hold_occ[%0d] got=%0d exp=1", i, occupancy); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (out_pc !== 32'h14 || out_instr !== 32'h2222_0013) begin bad++; $display("FAIL bp_second pc=%h instr=%h exp pc=00000014 instr=22220013", out_pc, out_instr); end
`endif
    step();
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL bp_drain valid=%b occ=%0d exp valid=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h18; in_instr = 32'h3333_0013;
    step();
`ifdef PIPE_STAGE_SKID_EN
    in_pc = 32'h1C; in_instr = 32'h4444_0013;
    step();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_fill_occ got=%0d exp=2", occupancy); end
`else
    total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL flush_fill_occ got=%0d exp=1", occupancy); end
`endif
    flush = 1'b1; in_pc = 32'h20; in_instr = 32'h5555_0013;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    total++; if (out_instr !== NOP) begin bad++; $display("FAIL flush_instr got=%h exp=%h", out_instr, NOP); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0 || out_pc === 32'h20) begin bad++; $display("FAIL flush_leak[%0d] valid=%b pc=%h exp valid=0", i, out_valid, out_pc); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h30; in_instr = 32'h6666_0013;
    step();
    total++; if (out_pc !== 32'h30 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_first pc=%h valid=%b exp pc=00000030 valid=1", out_pc, out_valid); end
    in_pc = 32'h34; in_instr = 32'h7777_0013;
    step();
    in_valid = 1'b0;
    total++; if (out_pc !== 32'h34 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_second pc=%h valid=%b exp pc=00000034 valid=1", out_pc, out_valid); end
    total++; if (out_instr !== 32'h7777_0013) begin bad++; $display("FAIL b2b_instr got=%h exp=77770013", out_instr); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'h8888_0013;
    step();
    in_pc = 32'h44; in_instr = 32'h9999_0013;
    step();
`ifdef PIPE_STAGE_SKID_EN
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL rmid_occ_pre got=%0d exp=2", occupancy); end
`else
    total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL rmid_occ_pre got=%0d exp=1", occupancy); end
`endif
    reset = 1'b1; in_pc = 32'h48;
    step();
    reset = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin bad++; $display("FAIL rmid_out valid=%b pc=%h exp valid=0 pc=00000000", out_valid, out_pc); end
    total++; if (out_instr !== NOP || occupancy !== 2'd0) begin bad++; $display("FAIL rmid_state instr=%h occ=%0d exp instr=%h occ=0", out_instr, occupancy, NOP); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h50; in_instr = 32'hAAAA_0013;
    step();
    in_valid = 1'b0;
    total++; if (out_pc !== 32'h50 || out_valid !== 1'b1) begin bad++; $display("FAIL rmid_post pc=%h valid=%b exp pc=00000050 valid=1", out_pc, out_valid); end
    step();
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL rmid_drain valid=%b occ=%0d exp valid=0 occ=0", out_valid, occupancy); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
